// File: rtl/ks_datapath_p.sv
`default_nettype none
// ============================================================================
//  Module   : ks_datapath_p
//  Purpose  : Parametrised K&S processor datapath. It holds the PC, the IR,
//             the register file, the ALU and the registered flags. It drives
//             the RAM address and write-data buses, and decodes the IR
//             opcode for the control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module ks_datapath_p #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              pc_enable,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic              write_reg_enable,
  input  logic              flags_enable,
  input  logic [2:0]        operation,
  output logic [4:0]        decoded_instruction,
  output logic              zero,
  output logic              neg,
  output logic              unsigned_overflow,
  output logic              signed_overflow,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr_ram
);

  localparam int c_RW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int c_MSB = DATA_W - 1;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_rf [NREG];

  logic [7:0]        w_opcode;
  logic [c_RW-1:0]   w_a, w_b, w_c;
  logic [ADDR_W-1:0] w_ir_addr;
  logic [DATA_W-1:0] w_bus_a, w_bus_b, w_alu, w_wb;
  logic [DATA_W:0]   w_sum, w_diff;
  logic              w_uovf, w_sovf;
  logic              w_unused;

  // IR field extraction
  assign w_opcode  = r_ir[DATA_W-1 -: 8];
  assign w_c       = r_ir[c_RW-1:0];
  assign w_b       = r_ir[2*c_RW-1:c_RW];
  assign w_a       = r_ir[3*c_RW-1:2*c_RW];
  assign w_ir_addr = r_ir[ADDR_W-1:0];
  // Not every IR bit is a field for every parameter set.
  assign w_unused  = ^r_ir;

  // Combinational register reads and bus drives (no write bypass)
  assign w_bus_a  = r_rf[w_a];
  assign w_bus_b  = r_rf[w_b];
  assign data_in  = w_bus_a;
  assign addr_ram = addr_sel ? w_ir_addr : r_pc;

  // Extended-width add/sub so the carry and borrow fall out as the top bit
  assign w_sum  = {1'b0, w_bus_a} + {1'b0, w_bus_b};
  assign w_diff = {1'b0, w_bus_a} - {1'b0, w_bus_b};

  // ALU result and the overflow flags that go with it
  always_comb begin
    w_alu  = '0;
    w_uovf = 1'b0;
    w_sovf = 1'b0;
    case (operation)
      3'b000: begin
        w_alu  = w_sum[DATA_W-1:0];
        w_uovf = w_sum[DATA_W];
        w_sovf = (w_bus_a[c_MSB] == w_bus_b[c_MSB]) && (w_sum[c_MSB] != w_bus_a[c_MSB]);
      end
      3'b001: begin
        w_alu  = w_diff[DATA_W-1:0];
        w_uovf = w_diff[DATA_W];
        w_sovf = (w_bus_a[c_MSB] != w_bus_b[c_MSB]) && (w_diff[c_MSB] != w_bus_a[c_MSB]);
      end
      3'b010: w_alu = w_bus_a & w_bus_b;
      3'b011: w_alu = w_bus_a | w_bus_b;
      3'b100: w_alu = w_bus_a ^ w_bus_b;
      3'b101: begin
        w_alu  = {w_bus_a[DATA_W-2:0], 1'b0};
        w_uovf = w_bus_a[c_MSB];
      end
      3'b110: begin
        w_alu  = {1'b0, w_bus_a[DATA_W-1:1]};
        w_uovf = w_bus_a[0];
      end
      default: w_alu = w_bus_a;
    endcase
  end

  assign w_wb = c_sel ? w_alu : data_out;

  // Opcode to instruction-class decode; unknown opcodes are treated as NOP
  always_comb begin
    decoded_instruction = 5'd0;
    case (w_opcode)
      8'h01: decoded_instruction = 5'd1;
      8'h02: decoded_instruction = 5'd2;
      8'h03: decoded_instruction = 5'd3;
      8'h04: decoded_instruction = 5'd4;
      8'h05: decoded_instruction = 5'd5;
      8'h06: decoded_instruction = 5'd6;
      8'h07: decoded_instruction = 5'd7;
      8'h81: decoded_instruction = 5'd8;
      8'h82: decoded_instruction = 5'd9;
      8'h91: decoded_instruction = 5'd10;
      8'hA1: decoded_instruction = 5'd11;
      8'hA2: decoded_instruction = 5'd12;
      8'hA3: decoded_instruction = 5'd13;
      8'hA4: decoded_instruction = 5'd14;
      8'hA5: decoded_instruction = 5'd15;
      8'hA6: decoded_instruction = 5'd16;
      8'hA7: decoded_instruction = 5'd17;
      8'hFF: decoded_instruction = 5'd31;
      default: decoded_instruction = 5'd0;
    endcase
  end

  // PC and IR: the PC branch target comes from the IR value before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (pc_enable) r_pc <= branch ? w_ir_addr : r_pc + ADDR_W'(1);
      if (ir_enable) r_ir <= data_out;
    end
  end

  // Register-file write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (write_reg_enable) begin
      r_rf[w_c] <= w_wb;
    end
  end

  // Flag latch, loaded only on an explicit strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      zero              <= 1'b0;
      neg               <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_enable) begin
      zero              <= (w_alu == '0);
      neg               <= w_alu[c_MSB];
      unsigned_overflow <= w_uovf;
      signed_overflow   <= w_sovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ks_datapath_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ks_datapath_p
//  Purpose  : Self-checking bench for ks_datapath_p. It runs directed
//             scenarios, then randomized traffic, against an arithmetic
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ks_datapath_p;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREG   = 4;
  localparam longint M  = 64'd1 << DATA_W;

  logic              clk = 1'b0;
  logic              rst, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic              write_reg_enable, flags_enable;
  logic [2:0]        operation;
  logic [4:0]        decoded_instruction;
  logic              zero, neg, unsigned_overflow, signed_overflow;
  logic [DATA_W-1:0] data_out, data_in;
  logic [ADDR_W-1:0] addr_ram;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  longint m_rf [NREG];
  longint m_pc, m_ir;
  bit     m_z, m_n, m_u, m_s;

  ks_datapath_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .write_reg_enable(write_reg_enable), .flags_enable(flags_enable),
    .operation(operation), .decoded_instruction(decoded_instruction),
    .zero(zero), .neg(neg), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .data_out(data_out),
    .data_in(data_in), .addr_ram(addr_ram)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint dec_ref(input longint opc);
    case (opc)
      8'h00: return 0;  8'h01: return 1;  8'h02: return 2;  8'h03: return 3;
      8'h04: return 4;  8'h05: return 5;  8'h06: return 6;  8'h07: return 7;
      8'h81: return 8;  8'h82: return 9;  8'h91: return 10; 8'hA1: return 11;
      8'hA2: return 12; 8'hA3: return 13; 8'hA4: return 14; 8'hA5: return 15;
      8'hA6: return 16; 8'hA7: return 17; 8'hFF: return 31;
      default: return 0;
    endcase
  endfunction

  function automatic longint to_signed(input longint v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // ALU reference written as plain integer arithmetic
  task automatic ref_alu(input int op, input longint a, input longint b,
                         output longint res, output bit u, output bit s);
    longint full;
    u = 0; s = 0;
    case (op)
      0: begin
        full = a + b; res = full % M; u = (full >= M);
        full = to_signed(a) + to_signed(b); s = (full >= M / 2) || (full < -(M / 2));
      end
      1: begin
        res = (a - b + M) % M; u = (a < b);
        full = to_signed(a) - to_signed(b); s = (full >= M / 2) || (full < -(M / 2));
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * 2) % M; u = (a >= M / 2); end
      6: begin res = a / 2; u = (a % 2) == 1; end
      default: res = a;
    endcase
  endtask

  // One clock cycle: drive, compare visible state against the model, clock, advance the model
  task automatic cycle(input bit i_rst, input bit i_br, input bit i_pce, input bit i_ire,
                       input bit i_asel, input bit i_csel, input bit i_wre, input bit i_fe,
                       input int i_op, input longint i_dout);
    longint res, ia, ib, ic, iaddr;
    bit u, s;
    rst = i_rst; branch = i_br; pc_enable = i_pce; ir_enable = i_ire;
    addr_sel = i_asel; c_sel = i_csel; write_reg_enable = i_wre;
    flags_enable = i_fe; operation = 3'(i_op); data_out = DATA_W'(i_dout);
    ia = (m_ir >> 4) % 4; ib = (m_ir >> 2) % 4; ic = m_ir % 4; iaddr = m_ir % 32;
    #1;
    check_val("addr_ram", addr_ram, i_asel ? iaddr : m_pc);
    check_val("data_in", data_in, m_rf[ia]);
    check_val("decode", decoded_instruction, dec_ref(m_ir / 256));
    check_val("flags", {zero, neg, unsigned_overflow, signed_overflow}, {m_z, m_n, m_u, m_s});
    @(posedge clk);
    if (i_rst) begin
      for (int k = 0; k < NREG; k++) m_rf[k] = 0;
      m_pc = 0; m_ir = 0; {m_z, m_n, m_u, m_s} = 4'b0;
    end else begin
      ref_alu(i_op, m_rf[ia], m_rf[ib], res, u, s);
      if (i_wre) m_rf[ic] = i_csel ? res : i_dout;
      if (i_fe) begin m_z = (res == 0); m_n = (res >= M / 2); m_u = u; m_s = s; end
      if (i_pce) m_pc = i_br ? iaddr : (m_pc + 1) % 32;
      if (i_ire) m_ir = i_dout;
    end
    @(negedge clk);
  endtask

  task automatic probe(input bit asel);
    addr_sel = asel;
    #1;
  endtask

  // Load register rc with a constant through a LOAD-shaped IR
  task automatic load_reg(input int rc, input longint val);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8100 + rc);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, val);
  endtask

  initial begin
    longint dv;
    int sel;
    for (int k = 0; k < NREG; k++) m_rf[k] = 0;
    m_pc = 0; m_ir = 0; {m_z, m_n, m_u, m_s} = 4'b0;
    rst = 1; branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    write_reg_enable = 0; flags_enable = 0; operation = 0; data_out = 0;
    @(negedge clk);

    // Reset wins over every enable
    cycle(1, 1, 1, 1, 0, 1, 1, 1, 0, 16'hFFFF);
    probe(0);
    check_val("rst_addr", addr_ram, 0);
    check_val("rst_dec", decoded_instruction, 0);
    check_val("rst_data_in", data_in, 0);
    check_val("rst_flags", {zero, neg, unsigned_overflow, signed_overflow}, 0);

    // PC wrap 31 -> 0, then LOAD fetch/decode
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h001F);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    probe(0); check_val("pc_31", addr_ram, 31);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    probe(0); check_val("pc_wrap", addr_ram, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8103);
    check_val("dec_load", decoded_instruction, 8);
    probe(1); check_val("addr_ir", addr_ram, 3);

    // Memory write-back, STORE data path, unknown opcode
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h1234);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8230);
    check_val("store_data", data_in, 16'h1234);
    check_val("dec_store", decoded_instruction, 9);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h5A00);
    check_val("dec_unknown", decoded_instruction, 0);

    // ADD signed overflow
    load_reg(1, 16'h7FFF); load_reg(2, 16'h0001);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'hA118);
    check_val("dec_add", decoded_instruction, 11);
    cycle(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    check_val("add_sovf", {zero, neg, unsigned_overflow, signed_overflow}, 4'b0101);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8200);
    check_val("add_r0", data_in, 16'h8000);

    // ADD carry out to zero
    load_reg(1, 16'hFFFF);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'hA118);
    cycle(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    check_val("add_carry", {zero, neg, unsigned_overflow, signed_overflow}, 4'b1010);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8200);
    check_val("add_zero_r0", data_in, 0);

    // SUB: flags hold without enable, then borrow
    load_reg(1, 16'h0000);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'hA218);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    check_val("sub_hold", {zero, neg, unsigned_overflow, signed_overflow}, 4'b1010);
    cycle(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    check_val("sub_borrow", {zero, neg, unsigned_overflow, signed_overflow}, 4'b0110);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8200);
    check_val("sub_r0", data_in, 16'hFFFF);

    // SHL shifts the MSB out
    load_reg(1, 16'h8001);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'hA618);
    cycle(0, 0, 0, 0, 0, 1, 1, 1, 5, 0);
    check_val("shl_flags", {zero, neg, unsigned_overflow, signed_overflow}, 4'b0010);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h8200);
    check_val("shl_r0", data_in, 16'h0002);

    // Branch, then reset with pc_enable
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0115);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    probe(0);
    check_val("branch_pc", addr_ram, 5'h15);
    check_val("dec_branch", decoded_instruction, 1);
    cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    probe(0); check_val("rst_pc", addr_ram, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      dv = {8'hA1 + 8'($urandom_range(0, 6)), 8'($urandom)};
      else if (sel == 1) dv = {8'($urandom_range(0, 7)), 8'($urandom)};
      else if (sel == 2) dv = {8'h81 + 8'($urandom_range(0, 1)), 8'($urandom)};
      else               dv = 16'($urandom);
      cycle($urandom_range(0, 40) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7), dv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ks_datapath_p.md
# ks_datapath_p

Parametrised successor of the K&S processor datapath: holds the program counter, instruction register, register file, ALU and a registered flag set, and drives the RAM address/write-data buses. The block has a configurable data width, address width and register count. It adds a 3-bit ALU operation set and explicitly enabled flag latching. It sits between the K&S control FSM, which drives the enables and reads the decode and flags, and the single-port program/data RAM.

## Interface
- DATA_W, 16, data/instruction word width; must be ≥ 8+3·RW and ≥ 8+ADDR_W
- ADDR_W, 5, RAM address width and PC width
- NREG, 4, register-file depth, power of two ≥ 2; RW = $clog2(NREG)
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- branch  in  1  PC load source: 1 = IR address field, 0 = PC+1
- pc_enable  in  1  PC update strobe
- ir_enable  in  1  IR load from data_out
- addr_sel  in  1  addr_ram source: 0 = PC, 1 = IR address field
- c_sel  in  1  write-back source: 1 = ALU result, 0 = data_out
- write_reg_enable  in  1  register-file write strobe
- flags_enable  in  1  flag-register load strobe
- operation  in  3  ALU op
- decoded_instruction  out  5  instruction class to control
- zero, neg, unsigned_overflow, signed_overflow  out  1 each  registered flags
- data_out  in  DATA_W  RAM read data
- data_in  out  DATA_W  RAM write data
- addr_ram  out  ADDR_W  RAM address

## Operation
- IR fields:
  - opcode = ir[DATA_W-1 -: 8]
  - c = ir[RW-1:0], b = ir[2RW-1:RW], a = ir[3RW-1:2RW]
  - memory/branch address = ir[ADDR_W-1:0]
- Register reads are combinational: bus_a = R[a], bus_b = R[b]. data_in = bus_a.
- addr_ram is combinational: addr_sel ? ir addr field : pc.
- ALU, by operation:
  - 000 ADD, 001 SUB (a−b), 010 AND, 011 OR, 100 XOR
  - 101 SHL a by 1, 110 SHR a by 1 (logical), 111 PASS a
  - Result is truncated to DATA_W.
- Flags, latched from the current ALU result only when flags_enable=1; they hold otherwise:
  - zero = (result == 0); neg = result MSB
  - unsigned_overflow: carry-out for ADD, borrow for SUB, the bit shifted out for SHL/SHR, 0 for the others
  - signed_overflow: two's-complement overflow for ADD/SUB, 0 for the others
- Write-back: when write_reg_enable=1, R[c] ← (c_sel ? alu : data_out).
- PC: when pc_enable=1, pc ← branch ? ir addr field : (pc+1) mod 2^ADDR_W. Wrap from all-ones to 0 is silent.
- Decode is combinational from the IR opcode. Mapping (opcode → code):
  - Branches: 0x00 NOP→0, 0x01 BRANCH→1, 0x02 BZERO→2, 0x03 BNEG→3, 0x04 BOV→4, 0x05 BNOV→5, 0x06 BNNEG→6, 0x07 BNZERO→7
  - Memory/move: 0x81 LOAD→8, 0x82 STORE→9, 0x91 MOVE→10
  - ALU: 0xA1 ADD→11, 0xA2 SUB→12, 0xA3 AND→13, 0xA4 OR→14, 0xA5 XOR→15, 0xA6 SHL→16, 0xA7 SHR→17
  - 0xFF HALT→31; any other opcode → 0 (NOP)
- Branch condition evaluation belongs to control. The datapath only exposes the flags.

## Timing
- Reset (rst=1 at a clk edge): pc=0, ir=0, all R=0, all flags=0.
  - After reset, decoded_instruction=0, data_in=0, and addr_ram=0 when addr_sel=0.
  - Reset overrides every simultaneous enable.
- PC, IR, register file and flags all update on the same rising edge as their enable. Each new value is visible in the following cycle.
- Fetch-to-decode latency is 1 cycle: ir_enable at edge N gives a valid decoded_instruction after edge N.
- Read-during-write on the same register: combinational reads return the old value until the edge; the new value appears in the next cycle. No bypass.
- Flags and write-back use the same ALU result in the same cycle, so ADD with write_reg_enable=1 and flags_enable=1 updates both at one edge.
- ir_enable and pc_enable in the same cycle: the PC uses the old IR address field.

## Test plan
Defaults DATA_W=16, ADDR_W=5, NREG=4; field layout a=ir[5:4], b=ir[3:2], c=ir[1:0].

- Reset with all enables high → pc=0, decoded_instruction=0, data_in=0x0000, addr_ram=0 (addr_sel=0), all flags 0.
- pc=31, pc_enable=1, branch=0 → pc=0. Then data_out=0x8103, ir_enable=1 → decoded_instruction=8, and addr_ram=0x03 with addr_sel=1.
- With IR=0x8103, data_out=0x1234, c_sel=0, write_reg_enable=1 → R3=0x1234. Then IR=0x8230 (STORE, a=3) → data_in=0x1234. An unknown opcode such as 0x5A00 → decoded_instruction=0.
- ADD overflow checks, with IR=0xA118, op=000, c_sel=1, write_reg_enable=1, flags_enable=1:
  - R1=0x7FFF, R2=0x0001 → R0=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
  - R1=0xFFFF, R2=0x0001 → R0=0x0000, zero=1, unsigned_overflow=1, signed_overflow=0.
- SUB with R1=0x0000, R2=0x0001 (op=001):
  - flags_enable=0 → flags unchanged.
  - flags_enable=1 → result 0xFFFF, neg=1, unsigned_overflow=1.
  - SHL of 0x8001 with flags_enable=1 → 0x0002, unsigned_overflow=1.
- IR=0x0115, branch=1, pc_enable=1 → pc=0x15, decoded_instruction=1. Asserting rst in the next cycle with pc_enable=1 → pc=0.
